// File: rtl/instruction_fetch_unit.sv
// Fetch stage: program counter, combinational program-memory interface and
// the registered issue slot to decode, with HLT detection and issue counting.
module instruction_fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int INS_W  = 20,
    parameter logic [INS_W-1:0] NOP = '0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              stall_pm,
    input  logic              pc_mux_sel,
    input  logic [ADDR_W-1:0] jmp_loc,
    input  logic [INS_W-1:0]  pm_data,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [INS_W-1:0]  ins_pm,
    output logic [INS_W-1:0]  ins_out,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              halted,
    output logic [CNT_W-1:0]  issue_cnt
);

    localparam logic [4:0] OP_HLT = 5'b10001;

    logic [ADDR_W-1:0] pc;
    logic              issue;
    logic              halt_now;

    assign pm_addr = pc;
    assign ins_pm  = pm_data;

    always_comb begin
        issue    = !halted && !stall_pm;
        halt_now = issue && (pm_data[INS_W-1 -: 5] == OP_HLT);
    end

    // The PC also freezes on the edge that issues HLT, so it stays at the HLT address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= '0;
            ins_out   <= NOP;
            cur_addr  <= '0;
            halted    <= 1'b0;
            issue_cnt <= '0;
        end else begin
            if (!halted && !halt_now) begin
                if (pc_mux_sel)
                    pc <= jmp_loc;
                else if (!stall)
                    pc <= pc + 1'b1;
            end

            if (issue) begin
                ins_out  <= pm_data;
                cur_addr <= pc;
                if (issue_cnt != '1)
                    issue_cnt <= issue_cnt + 1'b1;
            end else begin
                ins_out <= NOP;
            end

            if (halt_now)
                halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a program-memory array feeds
// pm_data and stall/jump controls are driven by hand.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, stall_pm, pc_mux_sel;
    logic [7:0]  jmp_loc;
    logic [19:0] pm_data;
    logic [7:0]  pm_addr;
    logic [19:0] ins_pm;
    logic [19:0] ins_out;
    logic [7:0]  cur_addr;
    logic        halted;
    logic [15:0] issue_cnt;

    logic [19:0] pm [256];
    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;
    assign pm_data = pm[pm_addr];

    instruction_fetch_unit #(
        .ADDR_W(8),
        .INS_W (20),
        .NOP   (20'h00000),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .stall_pm  (stall_pm),
        .pc_mux_sel(pc_mux_sel),
        .jmp_loc   (jmp_loc),
        .pm_data   (pm_data),
        .pm_addr   (pm_addr),
        .ins_pm    (ins_pm),
        .ins_out   (ins_out),
        .cur_addr  (cur_addr),
        .halted    (halted),
        .issue_cnt (issue_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sp, input logic mux, input logic [7:0] jl);
        stall      = st;
        stall_pm   = sp;
        pc_mux_sel = mux;
        jmp_loc    = jl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) pm[i] = 20'h08000 | 20'(i);
        pm[8'h05] = 20'hA0005;   // LD
        pm[8'h0A] = 20'hE0040;   // jump
        pm[8'h12] = 20'h88000;   // HLT

        reset = 1'b1;
        drive(0, 0, 0, 8'h00);
        tick();
        tick();
        reset = 1'b0;

        // T1: move PC to 0x37, issue one word, then async reset
        drive(0, 1, 1, 8'h37);
        tick();
        check("t1_pc37", 32'(pm_addr), 32'h37);
        drive(0, 0, 0, 8'h00);
        tick();
        check("t1_pre_ins", 32'(ins_out), 32'h08037);
        reset = 1'b1;
        #1;
        check("t1_pm_addr", 32'(pm_addr), 32'h0);
        check("t1_ins_out", 32'(ins_out), 32'h0);
        check("t1_cur_addr", 32'(cur_addr), 32'h0);
        check("t1_halted", 32'(halted), 32'h0);
        check("t1_cnt", 32'(issue_cnt), 32'h0);
        #2;
        reset = 1'b0;

        // T2: linear fetch 0..3
        for (int i = 0; i < 4; i++) begin
            check("t2_pm_addr", 32'(pm_addr), 32'(i));
            tick();
            check("t2_ins_out", 32'(ins_out), 32'h08000 + 32'(i));
            check("t2_cur_addr", 32'(cur_addr), 32'(i));
        end
        check("t2_cnt", 32'(issue_cnt), 32'd4);

        // T3: LD at 0x05
        tick();
        check("t3_pm05", 32'(pm_addr), 32'h05);
        drive(1, 0, 0, 8'h00);
        tick();
        check("t3_ins_ld", 32'(ins_out), 32'hA0005);
        check("t3_cur_ld", 32'(cur_addr), 32'h05);
        check("t3_pm05b", 32'(pm_addr), 32'h05);
        drive(0, 1, 0, 8'h00);
        tick();
        check("t3_ins_nop", 32'(ins_out), 32'h0);
        check("t3_cur_nop", 32'(cur_addr), 32'h05);
        check("t3_pm06", 32'(pm_addr), 32'h06);
        drive(0, 0, 0, 8'h00);
        tick();
        check("t3_ins_06", 32'(ins_out), 32'h08006);
        check("t3_cur_06", 32'(cur_addr), 32'h06);
        check("t3_cnt", 32'(issue_cnt), 32'd7);

        // T4: jump at 0x0A to 0x40
        tick();
        tick();
        tick();
        check("t4_pm0a", 32'(pm_addr), 32'h0A);
        tick();
        check("t4_ins_jmp", 32'(ins_out), 32'hE0040);
        check("t4_pm0b", 32'(pm_addr), 32'h0B);
        drive(1, 1, 0, 8'h00);
        tick();
        check("t4_nop1", 32'(ins_out), 32'h0);
        check("t4_hold0b", 32'(pm_addr), 32'h0B);
        drive(1, 1, 1, 8'h40);
        tick();
        check("t4_nop2", 32'(ins_out), 32'h0);
        check("t4_cur_0a", 32'(cur_addr), 32'h0A);
        check("t4_pm40", 32'(pm_addr), 32'h40);
        drive(0, 0, 0, 8'h00);
        tick();
        check("t4_ins_40", 32'(ins_out), 32'h08040);
        check("t4_cur_40", 32'(cur_addr), 32'h40);
        check("t4_cnt", 32'(issue_cnt), 32'd12);

        // T5: HLT at 0x12
        drive(0, 1, 1, 8'h12);
        tick();
        check("t5_pm12", 32'(pm_addr), 32'h12);
        drive(0, 0, 0, 8'h00);
        tick();
        check("t5_ins_hlt", 32'(ins_out), 32'h88000);
        check("t5_halted", 32'(halted), 32'h1);
        check("t5_pm_frozen", 32'(pm_addr), 32'h12);
        check("t5_cnt", 32'(issue_cnt), 32'd13);
        drive(0, 0, 1, 8'h00);
        tick();
        check("t5_jmp_ignored", 32'(pm_addr), 32'h12);
        check("t5_ins_nop", 32'(ins_out), 32'h0);
        check("t5_cnt_hold", 32'(issue_cnt), 32'd13);
        check("t5_halted_sticky", 32'(halted), 32'h1);
        drive(0, 0, 0, 8'h00);
        reset = 1'b1;
        #1;
        check("t5_rst_halted", 32'(halted), 32'h0);
        check("t5_rst_pm", 32'(pm_addr), 32'h0);
        #2;
        reset = 1'b0;

        // T6: PC wrap and counter saturation
        pm[8'h12] = 20'h08012;
        drive(0, 1, 1, 8'hFF);
        tick();
        check("t6_pmff", 32'(pm_addr), 32'hFF);
        drive(0, 0, 0, 8'h00);
        tick();
        check("t6_wrap", 32'(pm_addr), 32'h00);
        check("t6_ins_ff", 32'(ins_out), 32'h080FF);
        check("t6_cur_ff", 32'(cur_addr), 32'hFF);
        check("t6_cnt1", 32'(issue_cnt), 32'd1);
        for (int i = 0; i < 70000 && issue_cnt != 16'hFFFF; i++) tick();
        check("t6_cnt_max", 32'(issue_cnt), 32'hFFFF);
        tick();
        check("t6_cnt_sat", 32'(issue_cnt), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
